// File: rtl/lift_pkg.sv
// Shared types for the lift subsystem: floor numbering, FSM states and the target selector.
// Selection mode is chosen by the caller (SCAN when LIFT_CALL_SCAN_EN is defined in the scheduler).
package lift_pkg;

    localparam int NFLOORS = 4;

    typedef logic [1:0] floor_t;

    typedef enum logic [1:0] {IDLE, SERVE, HOLD} call_st_t;

    // avail must already exclude the current floor; there is no wrap-around in either direction.
    function automatic floor_t select_target(logic [NFLOORS-1:0] avail, floor_t cur,
                                             logic dir, logic scan);
        floor_t lowest;
        floor_t up_f;
        floor_t dn_f;
        logic   up_ok;
        logic   dn_ok;
        lowest = '0;
        up_f   = cur;
        dn_f   = cur;
        up_ok  = 1'b0;
        dn_ok  = 1'b0;
        for (int i = NFLOORS - 1; i >= 0; i--) begin
            if (avail[i]) lowest = floor_t'(i);
            if (avail[i] && i > int'(cur)) begin
                up_ok = 1'b1;
                up_f  = floor_t'(i);
            end
        end
        for (int i = 0; i < NFLOORS; i++) begin
            if (avail[i] && i < int'(cur)) begin
                dn_ok = 1'b1;
                dn_f  = floor_t'(i);
            end
        end
        if (!scan) return lowest;
        if (dir) return up_ok ? up_f : dn_f;
        return dn_ok ? dn_f : up_f;
    endfunction

endpackage

// File: rtl/lift_call_scheduler_if.sv
// Link between the call scheduler (master) and lift_controller (slave):
// target floor {B,A} with valid I, and the controller's current floor {Qb,Qa}.
interface lift_call_scheduler_if;

    logic A;
    logic B;
    logic I;
    logic Qa;
    logic Qb;

    modport master (output A, B, I, input Qa, Qb);
    modport slave  (input A, B, I, output Qa, Qb);

endinterface

// File: rtl/lift_btn_debounce.sv
// One call button: 2-flop synchroniser, saturating run-length counter and a single-cycle hit
// on the cycle the counter reaches DB_CYCLES.
module lift_btn_debounce #(
    parameter int DB_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic hit
);

    localparam logic [3:0] DB_MAX = 4'(DB_CYCLES);

    logic       sync1;
    logic       sync2;
    logic [3:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (!sync2)
                cnt <= '0;
            else if (cnt != DB_MAX)
                cnt <= cnt + 4'd1;
        end
    end

    // Fires as the counter steps onto DB_MAX; a held button then sits saturated and stays quiet.
    assign hit = sync2 && (cnt == DB_MAX - 4'd1);

endmodule

// File: rtl/lift_call_scheduler.sv
// Latches debounced floor calls and issues one target at a time to lift_controller.
// Define LIFT_CALL_SCAN_EN for direction-aware SCAN selection; otherwise lowest floor wins.
module lift_call_scheduler
    import lift_pkg::*;
#(
    parameter int DB_CYCLES   = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  CLK,
    input  logic                  RES,
    input  logic [NFLOORS-1:0]    BTN,
    output logic [NFLOORS-1:0]    PEND,
    lift_call_scheduler_if.master ctl
);

`ifdef LIFT_CALL_SCAN_EN
    localparam logic SCAN = 1'b1;
`else
    localparam logic SCAN = 1'b0;
`endif

    logic [NFLOORS-1:0] hit;
    logic [NFLOORS-1:0] cur_mask;
    logic [NFLOORS-1:0] avail;
    logic [NFLOORS-1:0] pend_next;
    floor_t             cur;
    floor_t             pick;
    floor_t             target;
    call_st_t           state;
    logic               dir;
    logic               valid;
    logic [3:0]         hold_cnt;

    for (genvar n = 0; n < NFLOORS; n++) begin : g_btn
        lift_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (CLK),
            .rst_n (RES),
            .btn   (BTN[n]),
            .hit   (hit[n])
        );
    end

    assign cur      = {ctl.Qb, ctl.Qa};
    assign cur_mask = NFLOORS'(1) << cur;
    assign avail    = PEND & ~cur_mask;
    assign pick     = select_target(avail, cur, dir, SCAN);

    // NOTE: defaulting pend_next first keeps this combinational block free of latches.
    always_comb begin
        pend_next = PEND | hit;
        case (state)
            IDLE, HOLD: pend_next = pend_next & ~cur_mask;
            SERVE:      if (cur == target) pend_next = pend_next & ~cur_mask;
            default:    pend_next = PEND | hit;
        endcase
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state    <= IDLE;
            target   <= '0;
            dir      <= 1'b1;
            valid    <= 1'b0;
            hold_cnt <= '0;
            PEND     <= '0;
        end else begin
            PEND <= pend_next;
            case (state)
                IDLE: begin
                    if (|avail) begin
                        target <= pick;
                        dir    <= (pick > cur);
                        valid  <= 1'b1;
                        state  <= SERVE;
                    end
                end
                SERVE: begin
                    if (cur == target) begin
                        valid    <= 1'b0;
                        hold_cnt <= 4'(HOLD_CYCLES);
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt - 4'd1;
                    if (hold_cnt <= 4'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ctl.A = target[0];
    assign ctl.B = target[1];
    assign ctl.I = valid;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed bench for lift_call_scheduler: a call-level model checked every cycle, plus
// hand-computed literal expectations at the key points of each scenario.
module tb_lift_call_scheduler;
    localparam int DB = 3;
    localparam int HOLD_N = 4;
`ifdef LIFT_CALL_SCAN_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif
    localparam int PH_IDLE = 0;
    localparam int PH_SERVE = 1;
    localparam int PH_HOLD = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = 4'h0;
    logic [3:0] pend;

    int vectors = 0;
    int miscompares = 0;

    lift_call_scheduler_if link ();

    lift_call_scheduler #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD_N)) dut (
        .CLK  (clk),
        .RES  (rst_n),
        .BTN  (btn),
        .PEND (pend),
        .ctl  (link)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] m_delay[$];
    int         m_run[4];
    logic [3:0] m_pend = 4'h0;
    int         m_phase = PH_IDLE;
    int         m_tgt = 0;
    bit         m_dir = 1'b1;
    bit         m_valid = 1'b0;
    int         m_dwell = 0;

    function automatic int m_choose(logic [3:0] p, int cur, bit up);
        if (!SCAN) begin
            for (int f = 0; f < 4; f++) if (p[f] && f != cur) return f;
            return cur;
        end
        for (int pass = 0; pass < 2; pass++) begin
            for (int d = 1; d < 4; d++) begin
                int f;
                f = up ? cur + d : cur - d;
                if (f >= 0 && f < 4 && p[f]) return f;
            end
            up = !up;
        end
        return cur;
    endfunction

    task automatic model_reset();
        m_delay = '{4'h0, 4'h0};
        for (int n = 0; n < 4; n++) m_run[n] = 0;
        m_pend  = 4'h0;
        m_phase = PH_IDLE;
        m_tgt   = 0;
        m_dir   = 1'b1;
        m_valid = 1'b0;
        m_dwell = 0;
    endtask

    task automatic model_edge();
        int         cur;
        logic [3:0] v;
        logic [3:0] hits;
        logic [3:0] others;
        bit         door_open;
        cur = int'({link.Qb, link.Qa});
        v = m_delay.pop_front();
        m_delay.push_back(btn);
        hits = 4'h0;
        for (int n = 0; n < 4; n++) begin
            m_run[n] = v[n] ? m_run[n] + 1 : 0;
            if (m_run[n] == DB) hits[n] = 1'b1;
        end
        door_open = (m_phase != PH_SERVE) || (cur == m_tgt);
        others = m_pend;
        others[cur] = 1'b0;
        case (m_phase)
            PH_IDLE: if (others != 4'h0) begin
                m_tgt   = m_choose(others, cur, m_dir);
                m_dir   = (m_tgt > cur);
                m_valid = 1'b1;
                m_phase = PH_SERVE;
            end
            PH_SERVE: if (cur == m_tgt) begin
                m_valid = 1'b0;
                m_dwell = HOLD_N;
                m_phase = PH_HOLD;
            end
            default: begin
                m_dwell--;
                if (m_dwell == 0) m_phase = PH_IDLE;
            end
        endcase
        m_pend = m_pend | hits;
        if (door_open) m_pend[cur] = 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_edge();
    end

    always @(negedge clk) begin
        check("model_ba", {2'b00, link.B, link.A}, 4'(m_tgt));
        check("model_i", {3'b000, link.I}, {3'b000, m_valid});
        check("model_pend", pend, m_pend);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn = 4'h0;
        link.Qa = 1'b0;
        link.Qb = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic press(input logic [3:0] b);
        btn = b;
        repeat (DB + 2) step();
        btn = 4'h0;
    endtask

    initial begin
        link.Qa = 1'b0;
        link.Qb = 1'b0;

        // Reset with all buttons held
        btn = 4'hF;
        repeat (10) step();
        check("rst_pend", pend, 4'h0);
        check("rst_i", {3'b000, link.I}, 4'h0);
        check("rst_ba", {2'b00, link.B, link.A}, 4'h0);
        rst_n = 1'b1;
        repeat (4) step();
        check("rst_pend_early", pend, 4'h0);
        step();
        check("rst_pend_held", pend, 4'b1110);
        check("rst_i_before_issue", {3'b000, link.I}, 4'h0);
        step();
        check("rst_issue_i", {3'b000, link.I}, 4'h1);
        check("rst_issue_ba", {2'b00, link.B, link.A}, 4'd1);

        // Bounce rejection on floor 2
        do_reset();
        for (int i = 0; i < 20; i++) begin
            btn[2] = ~btn[2];
            step();
        end
        check("bounce_rejected", pend, 4'h0);
        btn[2] = 1'b1;
        repeat (4) step();
        check("bounce_hold_4", pend, 4'h0);
        step();
        check("bounce_hold_5", pend, 4'b0100);
        step();
        check("bounce_issue_ba", {2'b00, link.B, link.A}, 4'd2);
        btn = 4'h0;

        // Single call to floor 3, no retarget by a floor-2 call, dwell timing
        do_reset();
        btn = 4'b1000;
        repeat (5) step();
        check("single_pend", pend, 4'b1000);
        btn = 4'h0;
        step();
        check("single_i", {3'b000, link.I}, 4'h1);
        check("single_ba", {2'b00, link.B, link.A}, 4'd3);
        press(4'b0100);
        check("retarget_pend", pend, 4'b1100);
        check("retarget_ba", {2'b00, link.B, link.A}, 4'd3);
        step();
        link.Qa = 1'b1;
        link.Qb = 1'b1;
        step();
        check("arrive_i", {3'b000, link.I}, 4'h0);
        check("arrive_pend", pend, 4'b0100);
        for (int k = 0; k < HOLD_N; k++) begin
            step();
            check("dwell_i", {3'b000, link.I}, 4'h0);
        end
        step();
        check("next_i", {3'b000, link.I}, 4'h1);
        check("next_ba", {2'b00, link.B, link.A}, 4'd2);
        link.Qa = 1'b0;
        step();
        repeat (3) step();

        // Selection from floor 1 going up with floors 0 and 3 pending
        do_reset();
        press(4'b0010);
        step();
        link.Qa = 1'b1;
        step();
        repeat (HOLD_N + 1) step();
        btn = 4'b1001;
        repeat (5) step();
        check("simul_pend", pend, 4'b1001);
        btn = 4'h0;
        step();
        check("select_i", {3'b000, link.I}, 4'h1);
        check("select_ba", {2'b00, link.B, link.A}, SCAN ? 4'd3 : 4'd0);

        // Only floor 0 pending from floor 1 going up: reverses in SCAN, lowest otherwise
        do_reset();
        press(4'b0010);
        step();
        link.Qa = 1'b1;
        step();
        repeat (HOLD_N + 1) step();
        press(4'b0001);
        step();
        check("reverse_ba", {2'b00, link.B, link.A}, 4'd0);
        check("reverse_i", {3'b000, link.I}, 4'h1);

        // Asynchronous reset in SERVE
        rst_n = 1'b0;
        #1;
        check("async_i", {3'b000, link.I}, 4'h0);
        check("async_pend", pend, 4'h0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
